csync_decoder: RTL and testbench
================================

# csync_decoder

Decodes the synchronised, active-low composite sync from the VP415 RGB input synchroniser. Produces per-line and per-field timing strobes, field parity, a line count and a lock flag. Pulse classification is by low-pulse width, measured in 81 MHz clocks (PAL: line 5184 clk, hsync ≈381, equalising ≈190, broad ≈2214). The outputs feed the downstream capture/overlay logic, which aligns the equally delayed RGB to these strobes.

## Interface
Parameters:
- GLITCH_MAX, 63: low pulses of this width or less are ignored.
- EQ_MAX, 284: widths from GLITCH_MAX+1 to EQ_MAX are equalising pulses.
- HS_MAX, 1000: widths from EQ_MAX+1 to HS_MAX are hsync; widths above HS_MAX are broad.
- HALF_MIN, 2400 / HALF_MAX, 2800: window for the falling-to-falling half-line period.
- LINE_TIMEOUT, 10368: clocks without any falling edge before loss of sync.
- LINES_MIN, 300 / LINES_MAX, 320: acceptable hsync count per field.

Ports:
- clk  in  1  81 MHz system clock
- rst_n  in  1  synchronous reset, active low (one clock; reset is synchronous and active-low)
- csync_sync  in  1  synchronised composite sync, low = sync
- hsync_stb  out  1  one-cycle strobe at the end of each valid hsync pulse
- eq_stb  out  1  one-cycle strobe at the end of each equalising pulse
- field_stb  out  1  one-cycle strobe at the end of the first broad pulse of a field
- field_odd  out  1  parity of the current field
- line_count  out  10  hsync count since the last field_stb, saturating at 1023
- locked  out  1  stable PAL sync detected

## Operation
- **Edge detection:** a one-cycle-delayed copy of csync_sync detects falls (1→0) and rises (0→1).
- **Width counter (13 b):**
  - Cleared to 1 on a fall and incremented while low; saturates at 8191.
  - On a rise, the width is classified as glitch, eq, hs or broad. A glitch produces no strobe and no state change.
- **Period counter (14 b):**
  - Counts clocks since the last accepted fall; saturates.
  - Reloaded only on a fall whose pulse is later classified non-glitch. The previous value is latched as the period of that pulse.
- **FSM states:** LINES, PRE_EQ, BROAD, POST_EQ.
  - LINES → PRE_EQ on eq. Set field_odd = 1 if the latched period is within HALF_MIN..HALF_MAX, else 0.
  - PRE_EQ → BROAD on broad; assert field_stb.
  - LINES → BROAD on broad (equalising missed); assert field_stb; field_odd unchanged.
  - BROAD → POST_EQ on eq.
  - POST_EQ → LINES on hs.
  - An hs in PRE_EQ returns to LINES.
  - Any other class leaves the state unchanged.
- **Strobes:**
  - hsync_stb fires on every hs, in any state.
  - eq_stb fires on every eq.
- **line_count:**
  - Loaded with 0 on field_stb.
  - +1 on hsync_stb; saturates at 1023.
  - If field_stb and hsync_stb coincide (cannot occur by class), field_stb wins.
- **Lock:**
  - On each field_stb, count a good field if the outgoing line_count is within LINES_MIN..LINES_MAX; otherwise clear the good-field counter and locked.
  - Two consecutive good fields set locked.
- **Timeout:** period counter ≥ LINE_TIMEOUT forces the state to LINES and clears locked and the good-field counter. The timeout asserts continuously while csync is stuck high or low.
- **Reset values:** all outputs 0, state LINES, counters 0. The width counter holds 0 until the first fall after reset; a rise with no preceding fall since reset is ignored.

## Timing
- Fall seen at cycle T (csync_sync low at T, high at T−1); rise seen at cycle R. Width = R − T.
- Classification is registered. hsync_stb, eq_stb and field_stb are high for exactly cycle R+1.
- field_odd and state update at R+1.
- line_count and locked change on the clock edge ending cycle R+1, so they are visible from R+2.
- Timeout takes effect the cycle after the counter reaches LINE_TIMEOUT.
- Minimum spacing between strobes is GLITCH_MAX+2 cycles. No back-to-back strobes.
- Reset asserted mid-pulse discards the pulse. After release, the first strobe requires a complete fall/rise pair.

## Structure
- Package vp415_sync_pkg holds:
  - the pulse-class enum (GLITCH, EQ, HS, BROAD) and the FSM state enum;
  - default PAL timing constants at 81 MHz, used as parameter defaults.
- Sub-module csync_pulse_meter: edge detect, width counter, period latch and classifier. It outputs a one-cycle class-valid, the class, and the latched period.
- The top level holds the FSM, line counter, lock and timeout logic.

## Test plan
- **Reset:** hold rst_n low with csync toggling → all outputs 0. After release, a 381-clk low pulse → hsync_stb only at R+1; line_count = 1 from R+2.
- **Glitch rejection:** 40-clk low pulse mid-line → no strobe; period reference unchanged. The next hs at 5184 clk is classified normally.
- **Odd/even fields:** full PAL field-1 sequence (5 eq, 5 broad, 5 eq, then hs) → field_stb once, field_odd = 1, state LINES after the first hs. The field-2 sequence (full-line gap before the first eq) → field_odd = 0.
- **Lock:**
  - Two consecutive fields of 305 hs → locked = 1 from R+2 of the second field_stb.
  - A third field of 250 hs → locked = 0 at that field_stb.
- **Timeout:** locked design; csync held high 10368 clk → locked = 0 and state LINES. Same result with csync held low 10368 clk; no strobes in either case.
- **Missed equalising:** broad pulse arriving in LINES → field_stb; line_count = 0; field_odd unchanged.

Source files
------------

// File: rtl/vp415_sync_pkg.sv
// Shared types and default PAL timing (81 MHz clocks) for the VP415 composite sync decoder.
package vp415_sync_pkg;

  typedef enum logic [1:0] {GLITCH, EQ, HS, BROAD} pulse_cls_t;
  typedef enum logic [1:0] {ST_LINES, ST_PRE_EQ, ST_BROAD, ST_POST_EQ} sync_state_t;

  localparam int WIDTH_W  = 13;
  localparam int PERIOD_W = 14;
  localparam int LINE_W   = 10;

  localparam int PAL_GLITCH_MAX   = 63;
  localparam int PAL_EQ_MAX       = 284;
  localparam int PAL_HS_MAX       = 1000;
  localparam int PAL_HALF_MIN     = 2400;
  localparam int PAL_HALF_MAX     = 2800;
  localparam int PAL_LINE_TIMEOUT = 10368;
  localparam int PAL_LINES_MIN    = 300;
  localparam int PAL_LINES_MAX    = 320;

  function automatic pulse_cls_t classify(input logic [WIDTH_W-1:0] w,
                                          input int glitch_max,
                                          input int eq_max,
                                          input int hs_max);
    if (int'(w) <= glitch_max)  return GLITCH;
    else if (int'(w) <= eq_max) return EQ;
    else if (int'(w) <= hs_max) return HS;
    else                        return BROAD;
  endfunction

endpackage

// File: rtl/csync_decoder_if.sv
// Composite sync input and decoded timing outputs, grouped for the decoder port.
interface csync_decoder_if;
  import vp415_sync_pkg::*;

  logic              csync_sync;
  logic              hsync_stb;
  logic              eq_stb;
  logic              field_stb;
  logic              field_odd;
  logic [LINE_W-1:0] line_count;
  logic              locked;

  modport master (output csync_sync,
                  input  hsync_stb, eq_stb, field_stb, field_odd, line_count, locked);
  modport slave  (input  csync_sync,
                  output hsync_stb, eq_stb, field_stb, field_odd, line_count, locked);
endinterface

// File: rtl/csync_pulse_meter.sv
// Measures low-pulse width and falling-edge period of csync, classifies each completed pulse.
module csync_pulse_meter
  import vp415_sync_pkg::*;
#(
  parameter int GLITCH_MAX = PAL_GLITCH_MAX,
  parameter int EQ_MAX     = PAL_EQ_MAX,
  parameter int HS_MAX     = PAL_HS_MAX
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                csync_sync,
  output logic                cls_vld,
  output pulse_cls_t          cls,
  output logic [PERIOD_W-1:0] period,
  output logic [PERIOD_W-1:0] since_fall
);

  logic                csync_d;
  logic                fall;
  logic                rise;
  logic [WIDTH_W-1:0]  width_cnt;
  logic [PERIOD_W-1:0] period_cand;

  // Tracks csync through reset so a pulse already in progress at release is never seen as a fall.
  always_ff @(posedge clk) csync_d <= csync_sync;

  assign fall    = csync_d & ~csync_sync;
  assign rise    = ~csync_d & csync_sync;
  assign cls     = classify(width_cnt, GLITCH_MAX, EQ_MAX, HS_MAX);
  assign cls_vld = rise && (width_cnt != '0);
  assign period  = period_cand;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      width_cnt   <= '0;
      period_cand <= '0;
      since_fall  <= '0;
    end else begin
      if (fall) begin
        width_cnt   <= WIDTH_W'(1);
        period_cand <= since_fall;
      end else if (!csync_sync && (width_cnt != '0) && (width_cnt != '1)) begin
        width_cnt <= width_cnt + 1'b1;
      end

      // Reference moves to the fall only once its pulse proves not to be a glitch.
      if (cls_vld && (cls != GLITCH))
        since_fall <= PERIOD_W'(width_cnt) + 1'b1;
      else if (since_fall != '1)
        since_fall <= since_fall + 1'b1;
    end
  end

endmodule

// File: rtl/csync_decoder.sv
// Composite sync decoder: field-sequence FSM, line counter, lock and loss-of-sync timeout.
//   state      | meaning
//   ST_LINES   | active lines, hsync expected
//   ST_PRE_EQ  | pre-equalising pulses seen, waiting for broad
//   ST_BROAD   | broad (vsync) pulses
//   ST_POST_EQ | post-equalising pulses, waiting for first hsync
module csync_decoder
  import vp415_sync_pkg::*;
#(
  parameter int GLITCH_MAX   = PAL_GLITCH_MAX,
  parameter int EQ_MAX       = PAL_EQ_MAX,
  parameter int HS_MAX       = PAL_HS_MAX,
  parameter int HALF_MIN     = PAL_HALF_MIN,
  parameter int HALF_MAX     = PAL_HALF_MAX,
  parameter int LINE_TIMEOUT = PAL_LINE_TIMEOUT,
  parameter int LINES_MIN    = PAL_LINES_MIN,
  parameter int LINES_MAX    = PAL_LINES_MAX
) (
  input  logic            clk,
  input  logic            rst_n,
  csync_decoder_if.slave  bus
);

  logic                cls_vld;
  pulse_cls_t          cls;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] since_fall;

  sync_state_t         state, state_nxt;
  logic                odd_nxt, hs_nxt, eq_nxt, fld_nxt;
  logic                hsync_stb, eq_stb, field_stb, field_odd, locked;
  logic [LINE_W-1:0]   line_count;
  logic [1:0]          good_cnt;
  logic                half_ok, timeout, lines_ok;

  csync_pulse_meter #(
    .GLITCH_MAX (GLITCH_MAX),
    .EQ_MAX     (EQ_MAX),
    .HS_MAX     (HS_MAX)
  ) u_meter (
    .clk        (clk),
    .rst_n      (rst_n),
    .csync_sync (bus.csync_sync),
    .cls_vld    (cls_vld),
    .cls        (cls),
    .period     (period),
    .since_fall (since_fall)
  );

  assign half_ok  = (int'(period) >= HALF_MIN) && (int'(period) <= HALF_MAX);
  assign timeout  = int'(since_fall) >= LINE_TIMEOUT;
  assign lines_ok = (int'(line_count) >= LINES_MIN) && (int'(line_count) <= LINES_MAX);

  always_comb begin
    state_nxt = state;
    odd_nxt   = field_odd;
    hs_nxt    = 1'b0;
    eq_nxt    = 1'b0;
    fld_nxt   = 1'b0;
    if (cls_vld) begin
      hs_nxt = (cls == HS);
      eq_nxt = (cls == EQ);
      unique case (state)
        ST_LINES: begin
          if (cls == EQ) begin
            state_nxt = ST_PRE_EQ;
            odd_nxt   = half_ok;
          end else if (cls == BROAD) begin
            state_nxt = ST_BROAD;
            fld_nxt   = 1'b1;
          end
        end
        ST_PRE_EQ: begin
          if (cls == BROAD) begin
            state_nxt = ST_BROAD;
            fld_nxt   = 1'b1;
          end else if (cls == HS) begin
            state_nxt = ST_LINES;
          end
        end
        ST_BROAD:   if (cls == EQ) state_nxt = ST_POST_EQ;
        ST_POST_EQ: if (cls == HS) state_nxt = ST_LINES;
        default:    state_nxt = ST_LINES;
      endcase
    end
    if (timeout) state_nxt = ST_LINES;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_LINES;
      field_odd <= 1'b0;
      hsync_stb <= 1'b0;
      eq_stb    <= 1'b0;
      field_stb <= 1'b0;
    end else begin
      state     <= state_nxt;
      field_odd <= odd_nxt;
      hsync_stb <= hs_nxt;
      eq_stb    <= eq_nxt;
      field_stb <= fld_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_count <= '0;
      good_cnt   <= '0;
      locked     <= 1'b0;
    end else begin
      if (field_stb)
        line_count <= '0;
      else if (hsync_stb && (line_count != '1))
        line_count <= line_count + 1'b1;

      if (timeout) begin
        good_cnt <= '0;
        locked   <= 1'b0;
      end else if (field_stb) begin
        if (lines_ok) begin
          if (good_cnt != 2'd2) good_cnt <= good_cnt + 1'b1;
          locked <= (good_cnt != 2'd0);
        end else begin
          good_cnt <= '0;
          locked   <= 1'b0;
        end
      end
    end
  end

  assign bus.hsync_stb  = hsync_stb;
  assign bus.eq_stb     = eq_stb;
  assign bus.field_stb  = field_stb;
  assign bus.field_odd  = field_odd;
  assign bus.line_count = line_count;
  assign bus.locked     = locked;

endmodule

// File: tb/tb_csync_decoder.sv
// Directed bench for csync_decoder using a time-scaled PAL timing set (line = 100 clk).
module tb_csync_decoder;
  import vp415_sync_pkg::*;

  localparam int LINE = 100;
  localparam int HALF = 50;
  localparam int HS_W = 30;
  localparam int EQ_W = 15;
  localparam int BR_W = 44;
  localparam int GL_W = 5;
  localparam int TMO  = 200;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0, n_fail = 0;
  int   n_hs = 0, n_eq = 0, n_field = 0;

  csync_decoder_if bus();

  csync_decoder #(
    .GLITCH_MAX   (7),
    .EQ_MAX       (20),
    .HS_MAX       (40),
    .HALF_MIN     (45),
    .HALF_MAX     (55),
    .LINE_TIMEOUT (TMO),
    .LINES_MIN    (5),
    .LINES_MAX    (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.hsync_stb) n_hs++;
    if (bus.eq_stb)    n_eq++;
    if (bus.field_stb) n_field++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input int n);
    bus.csync_sync = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic line_hs();
    drive(1'b0, HS_W);
    drive(1'b1, LINE - HS_W);
  endtask

  task automatic eq_half();
    drive(1'b0, EQ_W);
    drive(1'b1, HALF - EQ_W);
  endtask

  task automatic broad_half();
    drive(1'b0, BR_W);
    drive(1'b1, HALF - BR_W);
  endtask

  // mode 0: full-line gap, 1: half-line gap, 2: full-line gap with a glitch at mid-line
  task automatic vsync(input int mode, input logic exp_odd, input logic lk_pre, input logic lk_post);
    int eq0, f0;
    eq0 = n_eq;
    f0  = n_field;
    case (mode)
      0: line_hs();
      1: begin drive(1'b0, HS_W); drive(1'b1, HALF - HS_W); end
      default: begin
        drive(1'b0, HS_W); drive(1'b1, HALF - HS_W);
        drive(1'b0, GL_W); drive(1'b1, HALF - GL_W);
      end
    endcase
    repeat (5) eq_half();
    bus.csync_sync = 1'b0;
    repeat (BR_W) @(negedge clk);
    bus.csync_sync = 1'b1;
    @(negedge clk);
    check_val("field_stb_r1", 32'(bus.field_stb), 32'd1);
    check_val("field_odd",    32'(bus.field_odd), 32'(exp_odd));
    check_val("locked_r1",    32'(bus.locked),    32'(lk_pre));
    @(negedge clk);
    check_val("field_stb_r2", 32'(bus.field_stb), 32'd0);
    check_val("line_cnt_clr", 32'(bus.line_count), 32'd0);
    check_val("locked_r2",    32'(bus.locked),    32'(lk_post));
    drive(1'b1, HALF - BR_W - 2);
    repeat (4) broad_half();
    repeat (5) eq_half();
    check_val("eq_per_vsync",    32'(n_eq - eq0),    32'd10);
    check_val("field_per_vsync", 32'(n_field - f0), 32'd1);
  endtask

  initial begin
    int tot;
    rst_n = 1'b0;
    bus.csync_sync = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      bus.csync_sync = ~bus.csync_sync;
      repeat (3) @(negedge clk);
    end
    check_val("rst_hsync", 32'(bus.hsync_stb),  32'd0);
    check_val("rst_eq",    32'(bus.eq_stb),     32'd0);
    check_val("rst_field", 32'(bus.field_stb),  32'd0);
    check_val("rst_odd",   32'(bus.field_odd),  32'd0);
    check_val("rst_lines", 32'(bus.line_count), 32'd0);
    check_val("rst_lock",  32'(bus.locked),     32'd0);

    // pulse already low at release must not be decoded
    bus.csync_sync = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 10);
    drive(1'b1, 20);
    check_val("no_stb_after_rst", 32'(n_hs + n_eq + n_field), 32'd0);

    bus.csync_sync = 1'b0;
    repeat (HS_W) @(negedge clk);
    bus.csync_sync = 1'b1;
    @(negedge clk);
    check_val("hs_r1",       32'(bus.hsync_stb),  32'd1);
    check_val("hs_r1_eq",    32'(bus.eq_stb),     32'd0);
    check_val("hs_r1_field", 32'(bus.field_stb),  32'd0);
    check_val("hs_r1_lines", 32'(bus.line_count), 32'd0);
    @(negedge clk);
    check_val("hs_r2",       32'(bus.hsync_stb),  32'd0);
    check_val("hs_r2_lines", 32'(bus.line_count), 32'd1);
    drive(1'b1, LINE - HS_W - 2);

    drive(1'b0, HS_W); drive(1'b1, 30); drive(1'b0, GL_W); drive(1'b1, LINE - HS_W - 30 - GL_W);
    check_val("glitch_hs_cnt", 32'(n_hs), 32'd2);
    check_val("glitch_eq_cnt", 32'(n_eq), 32'd0);
    line_hs();
    check_val("post_glitch_hs", 32'(n_hs), 32'd3);
    check_val("post_glitch_lines", 32'(bus.line_count), 32'd3);

    vsync(2, 1'b0, 1'b0, 1'b0);
    line_hs();
    check_val("state_after_hs", 32'(dut.state), 32'(ST_LINES));
    repeat (4) line_hs();
    vsync(1, 1'b1, 1'b0, 1'b0);
    repeat (5) line_hs();
    vsync(0, 1'b0, 1'b0, 1'b1);
    line_hs();
    vsync(1, 1'b1, 1'b1, 1'b0);
    repeat (5) line_hs();
    vsync(0, 1'b0, 1'b0, 1'b0);
    repeat (5) line_hs();
    vsync(1, 1'b1, 1'b0, 1'b1);

    tot = n_hs + n_eq + n_field;
    drive(1'b1, TMO + 10);
    check_val("tmo_hi_lock",  32'(bus.locked), 32'd0);
    check_val("tmo_hi_state", 32'(dut.state),  32'(ST_LINES));
    check_val("tmo_hi_stb",   32'(n_hs + n_eq + n_field), 32'(tot));

    repeat (5) line_hs();
    vsync(0, 1'b0, 1'b0, 1'b0);
    repeat (5) line_hs();
    vsync(1, 1'b1, 1'b0, 1'b1);

    tot = n_hs + n_eq + n_field;
    drive(1'b0, TMO + 10);
    check_val("tmo_lo_lock",  32'(bus.locked), 32'd0);
    check_val("tmo_lo_state", 32'(dut.state),  32'(ST_LINES));
    check_val("tmo_lo_stb",   32'(n_hs + n_eq + n_field), 32'(tot));
    drive(1'b1, HALF);

    repeat (3) line_hs();
    check_val("miss_eq_lines_pre", 32'(bus.line_count), 32'd3);
    bus.csync_sync = 1'b0;
    repeat (BR_W) @(negedge clk);
    bus.csync_sync = 1'b1;
    @(negedge clk);
    check_val("miss_eq_field", 32'(bus.field_stb), 32'd1);
    check_val("miss_eq_odd",   32'(bus.field_odd), 32'd1);
    @(negedge clk);
    check_val("miss_eq_lines", 32'(bus.line_count), 32'd0);
    drive(1'b1, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
